// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide engine:
// FSM encoding, iteration count and the two special operand constants.
package mult_div_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;

    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DATA_W-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unsigned magnitude; 0x80000000 maps to 2^31, which still fits 32 bits.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/mult_div_engine_if.sv
// Operand/control/result bundle between a requester and mult_div_engine.
interface mult_div_engine_if;
    import mult_div_pkg::*;

    logic signed [DATA_W-1:0] data_operandA;
    logic signed [DATA_W-1:0] data_operandB;
    logic                     ctrl_MULT;
    logic                     ctrl_DIV;
    logic signed [DATA_W-1:0] data_result;
    logic                     data_exception;
    logic                     data_resultRDY;
    logic                     busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/mult_div_addsub.sv
// Shared W-bit adder/subtractor: o_sum = i_a + i_b, or i_a - i_b when i_sub.
module mult_div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_a + (i_b ^ {W{i_sub}}) + {{(W-1){1'b0}}, i_sub};

endmodule

// File: rtl/mult_div_engine.sv
// Iterative signed 32-bit multiplier (shift-add) and divider (restoring),
// one bit per cycle on operand magnitudes, sign applied at the end.
module mult_div_engine #(
    parameter int ITER = mult_div_pkg::ITER
) (
    input  logic               clock,
    input  logic               reset,
    mult_div_engine_if.slave   bus
);
    import mult_div_pkg::*;

    localparam int              CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;

    logic [DATA_W-1:0]  r_opb;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic               r_neg;
    logic               r_bzero;
    logic               r_ovf;

    logic signed [DATA_W-1:0] r_result;
    logic                     r_exc;

    logic               w_busy_st;
    logic               w_start;
    logic               w_last;
    logic               w_iter;
    logic               w_fin;
    logic               w_sub;
    logic [DATA_W:0]    w_a;
    logic [DATA_W:0]    w_b;
    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_mul_step;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0]   w_quot;

    function automatic logic signed [2*DATA_W-1:0] apply_sign64(input logic [2*DATA_W-1:0] mag,
                                                                input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign32(input logic [DATA_W-1:0] mag,
                                                              input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    // A 64-bit value fits int32 when bits 63..31 are all equal.
    function automatic logic fits_int32(input logic signed [2*DATA_W-1:0] v);
        return (&v[2*DATA_W-1:DATA_W-1]) | ~(|v[2*DATA_W-1:DATA_W-1]);
    endfunction

    assign w_busy_st = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_start   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                       (bus.ctrl_MULT || bus.ctrl_DIV);
    assign w_last    = (r_cnt == LAST);
    assign w_iter    = w_busy_st && !w_last;
    assign w_fin     = w_busy_st && w_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.ctrl_MULT)     w_next = ST_MUL;
                else if (bus.ctrl_DIV) w_next = ST_DIV;
                else                   w_next = ST_IDLE;
            end
            ST_MUL, ST_DIV: begin
                if (w_last) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.data_resultRDY = (r_state == ST_DONE);
        bus.busy           = w_busy_st;
    end

    // Counts ITER iteration edges, then one extra edge for sign/finalise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      r_cnt <= '0;
        else if (w_start) r_cnt <= '0;
        else if (w_iter)  r_cnt <= r_cnt + 1'b1;
        else              r_cnt <= '0;
    end

    // MUL adds the multiplicand into the high half; DIV trial-subtracts the
    // divisor from {remainder, next dividend bit}.
    always_comb begin
        w_sub = (r_state == ST_DIV);
        w_b   = {1'b0, r_opb};
        w_a   = w_sub ? {r_hi, r_lo[DATA_W-1]} : {1'b0, r_hi};
        w_mul_step = r_lo[0] ? w_sum : {1'b0, r_hi};
    end

    mult_div_addsub #(.W(DATA_W + 1)) u_addsub (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_sub (w_sub),
        .o_sum (w_sum)
    );

    always_ff @(posedge clock) begin
        if (w_start) begin
            r_neg   <= bus.data_operandA[DATA_W-1] ^ bus.data_operandB[DATA_W-1];
            r_hi    <= '0;
            r_bzero <= (bus.data_operandB == '0);
            r_ovf   <= ($unsigned(bus.data_operandA) == INT_MIN) &&
                       ($unsigned(bus.data_operandB) == NEG_ONE);
            if (bus.ctrl_MULT) begin
                r_opb <= magnitude(bus.data_operandA);
                r_lo  <= magnitude(bus.data_operandB);
            end else begin
                r_opb <= magnitude(bus.data_operandB);
                r_lo  <= magnitude(bus.data_operandA);
            end
        end else if (w_iter) begin
            if (r_state == ST_MUL) begin
                r_hi <= w_mul_step[DATA_W:1];
                r_lo <= {w_mul_step[0], r_lo[DATA_W-1:1]};
            end else if (w_sum[DATA_W]) begin
                r_hi <= w_a[DATA_W-1:0];
                r_lo <= {r_lo[DATA_W-2:0], 1'b0};
            end else begin
                r_hi <= w_sum[DATA_W-1:0];
                r_lo <= {r_lo[DATA_W-2:0], 1'b1};
            end
        end
    end

    assign w_prod = apply_sign64({r_hi, r_lo}, r_neg);
    assign w_quot = apply_sign32(r_lo, r_neg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_fin) begin
            if (r_state == ST_MUL) begin
                r_result <= w_prod[DATA_W-1:0];
                r_exc    <= ~fits_int32(w_prod);
            end else if (r_bzero) begin
                r_result <= '0;
                r_exc    <= 1'b1;
            end else if (r_ovf) begin
                r_result <= INT_MIN;
                r_exc    <= 1'b1;
            end else begin
                r_result <= w_quot;
                r_exc    <= 1'b0;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;

endmodule

// File: tb/tb_mult_div_engine.sv
// Directed bench for mult_div_engine with a transaction-level reference model
// and a per-cycle compare process.
module tb_mult_div_engine;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mult_div_engine_if bus();

    mult_div_engine #(.ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          start;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    localparam longint LMIN = -64'sd2147483648;
    localparam longint LMAX =  64'sd2147483647;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          last_start = 0;
    exp_t        pend[$];
    logic [31:0] held_res;
    logic        held_exc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Signed semantics straight from the arithmetic definitions.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic mul,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     sa;
        int     sb;
        sa = $signed(a);
        sb = $signed(b);
        if (mul) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p < LMIN) || (p > LMAX);
        end else if (sb == 0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'(sa / sb);
            e = 1'b0;
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Every cycle: busy for E0..E32, a single RDY at E33, results held otherwise.
    initial begin
        bit exp_busy;
        bit exp_rdy;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                pend.delete();
                held_res = 32'h0;
                held_exc = 1'b0;
                check("reset busy", {31'b0, bus.busy}, 32'h0);
                check("reset rdy", {31'b0, bus.data_resultRDY}, 32'h0);
                check("reset result", bus.data_result, 32'h0);
                check("reset exception", {31'b0, bus.data_exception}, 32'h0);
            end else begin
                exp_busy = (pend.size() > 0) && (cyc >= pend[0].start) && (cyc <= pend[0].start + 32);
                exp_rdy  = (pend.size() > 0) && (cyc == pend[0].start + 33);
                check("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
                check("rdy", {31'b0, bus.data_resultRDY}, {31'b0, exp_rdy});
                if (exp_rdy) begin
                    held_res = pend[0].res;
                    held_exc = pend[0].exc;
                    void'(pend.pop_front());
                end
                check("result", bus.data_result, held_res);
                check("exception", {31'b0, bus.data_exception}, {31'b0, held_exc});
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic mul, input logic div);
        exp_t        e;
        logic [31:0] r;
        logic        x;
        model(a, b, mul, r, x);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        last_start = cyc + 1;
        e.start = last_start;
        e.res   = r;
        e.exc   = x;
        pend.push_back(e);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input string name, input logic [31:0] lit_r, input logic lit_e);
        int n = 0;
        while (bus.data_resultRDY !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (bus.data_resultRDY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no data_resultRDY within 60 cycles", name);
        end else begin
            check({name, " result"}, bus.data_result, lit_r);
            check({name, " exception"}, {31'b0, bus.data_exception}, {31'b0, lit_e});
            // RDY is high in the 34th cycle, counting the E0 cycle as the first.
            check({name, " latency"}, cyc - last_start + 1, 32'd34);
        end
    endtask

    task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic mul, input logic [31:0] lit_r, input logic lit_e);
        logic [31:0] r;
        logic        x;
        model(a, b, mul, r, x);
        check({name, " model result"}, r, lit_r);
        check({name, " model exception"}, {31'b0, x}, {31'b0, lit_e});
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic mul, input logic div,
                         input logic [31:0] lit_r, input logic lit_e);
        pin_model(name, a, b, mul, lit_r, lit_e);
        start_op(a, b, mul, div);
        wait_done(name, lit_r, lit_e);
    endtask

    initial begin
        int prev;
        reset             = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'h0;
        bus.data_operandB = 32'h0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        do_op("mul 7x-6", 32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0);
        @(negedge clock);
        do_op("mul 2^16x2^16", 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clock);
        do_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        @(negedge clock);
        do_op("div 5/0", 32'd5, 32'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        @(negedge clock);
        do_op("div INT_MIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        @(negedge clock);
        do_op("mul INT_MINx-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        @(negedge clock);
        do_op("mul -1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1, 1'b0);
        @(negedge clock);
        do_op("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        @(negedge clock);
        do_op("div -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b1, 32'd14, 1'b0);
        @(negedge clock);
        do_op("both ctrl 6x7", 32'd6, 32'd7, 1'b1, 1'b1, 32'd42, 1'b0);
        @(negedge clock);

        // Start requests while busy must be ignored.
        pin_model("mul 3x4", 32'd3, 32'd4, 1'b1, 32'd12, 1'b0);
        start_op(32'd3, 32'd4, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd5;
        @(negedge clock);
        bus.ctrl_DIV      = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        wait_done("mul 3x4", 32'd12, 1'b0);

        prev = last_start;
        do_op("b2b mul INT_MINx1", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h8000_0000, 1'b0);
        check("b2b pitch 1", last_start - prev, 32'd34);
        prev = last_start;
        do_op("b2b div INT_MIN/2", 32'h8000_0000, 32'd2, 1'b0, 1'b1, 32'hC000_0000, 1'b0);
        check("b2b pitch 2", last_start - prev, 32'd34);
        @(negedge clock);

        // Reset in cycle 10 of a divide; then a start on the first edge after release.
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        do_op("div 100/7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 1'b0);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
